// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one floating-point multiplier among NUM_REQ requesters.
// Latches the winner's operands, pulses mul_start, waits for mul_done under a watchdog, acks the winner.
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*32-1:0]  req_op1,
  input  logic [NUM_REQ*32-1:0]  req_op2,
  output logic [NUM_REQ-1:0]     ack,
  output logic [31:0]            rsp_result,
  output logic                   rsp_overflow,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic                   mul_start,
  output logic [31:0]            mul_op1,
  output logic [31:0]            mul_op2,
  input  logic                   mul_done,
  input  logic [31:0]            mul_result,
  input  logic                   mul_overflow
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   last_grant_r;
  logic [IDX_W-1:0]   grant_r;
  logic [IDX_W-1:0]   win_s;
  logic [IDX_W:0]     sum_s;
  logic               found_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               wd_expired_s;
  logic [31:0]        op1_sel_s;
  logic [31:0]        op2_sel_s;
  logic [31:0]        mul_op1_r;
  logic [31:0]        mul_op2_r;
  logic [31:0]        rsp_result_r;
  logic               rsp_overflow_r;
  logic               rsp_timeout_r;
  logic [NUM_REQ-1:0] ack_s;

  // Round-robin search: first set req bit above last_grant, wrapping around
  always_comb begin
    found_s = 1'b0;
    win_s   = last_grant_r;
    sum_s   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_s = {1'b0, last_grant_r} + (IDX_W + 1)'(k);
      if (sum_s >= NUM_EXT) begin
        sum_s = sum_s - NUM_EXT;
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && req[sum_s[IDX_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = sum_s[IDX_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Operand mux for the current round-robin winner
  always_comb begin
    op1_sel_s = 32'h0000_0000;
    op2_sel_s = 32'h0000_0000;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_s == IDX_W'(k)) begin
        op1_sel_s = req_op1[32*k +: 32];
        op2_sel_s = req_op2[32*k +: 32];
      end else begin
        op1_sel_s = op1_sel_s;
        op2_sel_s = op2_sel_s;
      end
    end
  end

  // Ack decode: one-hot of the stored grant while in RESP
  always_comb begin
    ack_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      ack_s[k] = (state_r == ST_RESP) && (grant_r == IDX_W'(k));
    end
  end

  assign wd_expired_s = (cnt_r == CNT_MAX);

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (mul_done || wd_expired_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: grant/operand latch, watchdog counter, response capture
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_grant_r   <= LAST_RST;
      grant_r        <= '0;
      cnt_r          <= '0;
      mul_op1_r      <= 32'h0000_0000;
      mul_op2_r      <= 32'h0000_0000;
      rsp_result_r   <= 32'h0000_0000;
      rsp_overflow_r <= 1'b0;
      rsp_timeout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_r   <= win_s;
            mul_op1_r <= op1_sel_s;
            mul_op2_r <= op2_sel_s;
          end
        end
        ST_ISSUE: cnt_r <= '0;
        ST_WAIT: begin
          // A done arriving on the last watchdog cycle still wins over the timeout
          if (mul_done) begin
            rsp_result_r   <= mul_result;
            rsp_overflow_r <= mul_overflow;
            rsp_timeout_r  <= 1'b0;
          end else if (wd_expired_s) begin
            rsp_result_r   <= 32'h0000_0000;
            rsp_overflow_r <= 1'b0;
            rsp_timeout_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: last_grant_r <= grant_r;
        default: last_grant_r <= last_grant_r;
      endcase
    end
  end

  assign ack          = ack_s;
  assign busy         = (state_r != ST_IDLE);
  assign mul_start    = (state_r == ST_ISSUE);
  assign mul_op1      = mul_op1_r;
  assign mul_op2      = mul_op2_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_overflow = rsp_overflow_r;
  assign rsp_timeout  = rsp_timeout_r;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter with a table-driven multiplier model.
module tb_fp_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  n_rst = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*32-1:0] req_op1 = '0;
  logic [NUM_REQ*32-1:0] req_op2 = '0;
  logic [NUM_REQ-1:0]    ack;
  logic [31:0]           rsp_result;
  logic                  rsp_overflow, rsp_timeout, busy, mul_start;
  logic [31:0]           mul_op1, mul_op2;
  logic                  mul_done;
  logic [31:0]           mul_result;
  logic                  mul_overflow;

  int   n_checks = 0;
  int   n_fail = 0;
  int   model_delay = 2;
  int   rem = 0;
  int   start_cnt = 0;
  logic model_ovf = 1'b0;
  logic force_done = 1'b0;

  fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_op1(req_op1), .req_op2(req_op2),
    .ack(ack), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_timeout(rsp_timeout), .busy(busy), .mul_start(mul_start),
    .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_done(mul_done),
    .mul_result(mul_result), .mul_overflow(mul_overflow)
  );

  always #5 clk = ~clk;

  // Hand-computed IEEE-754 single products for the operand pairs used here
  function automatic logic [31:0] fp_prod(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3FA00000, 32'h3FC00000}: return 32'h3FF00000;
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h40800000, 32'h40A00000}: return 32'h41A00000;
      {32'h3FC00000, 32'h40000000}: return 32'h40400000;
      {32'h3F000000, 32'h41000000}: return 32'h40800000;
      {32'h40000000, 32'h40200000}: return 32'h40A00000;
      {32'hC0400000, 32'hC0800000}: return 32'h41400000;
      {32'h3F800000, 32'h40E00000}: return 32'h40E00000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Multiplier model: done model_delay cycles after start (0 = never)
  always @(posedge clk) begin
    if (mul_start) rem <= model_delay;
    else if (rem > 0) rem <= rem - 1;
  end
  assign mul_done     = force_done | (rem == 1);
  assign mul_result   = mul_done ? fp_prod(mul_op1, mul_op2) : 32'h0;
  assign mul_overflow = mul_done & model_ovf;

  always @(negedge clk) if (mul_start) start_cnt++;

  task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_op1[32*idx +: 32] = a;
    req_op2[32*idx +: 32] = b;
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  // Waits up to budget negedges for an ack; lat = -1 when none arrived
  task automatic wait_ack(input int budget, output int lat, output logic [NUM_REQ-1:0] a);
    lat = -1;
    a = '0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        lat = i;
        a = ack;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected %b", ack, 4'b0000); end
    n_checks++; if ({busy, mul_start} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_start: got %b expected %b", {busy, mul_start}, 2'b00); end
    n_checks++; if ({mul_op1, mul_op2} !== 64'h0) begin n_fail++; $display("FAIL reset_ops: got %h expected %h", {mul_op1, mul_op2}, 64'h0); end
    n_checks++; if ({rsp_result, rsp_overflow, rsp_timeout} !== 34'h0) begin n_fail++; $display("FAIL reset_rsp: got %h expected %h", {rsp_result, rsp_overflow, rsp_timeout}, 34'h0); end
    n_rst = 1'b1;
  endtask

  task automatic test_single();
    int lat;
    int s0;
    logic [NUM_REQ-1:0] a;
    @(negedge clk);
    model_delay = 2;
    set_ops(0, 32'h3FA00000, 32'h3FC00000);
    req = 4'b0001;
    s0 = start_cnt;
    @(negedge clk);
    n_checks++; if ({mul_start, busy} !== 2'b11) begin n_fail++; $display("FAIL single_issue: got %b expected %b", {mul_start, busy}, 2'b11); end
    n_checks++; if (mul_op1 !== 32'h3FA00000 || mul_op2 !== 32'h3FC00000) begin n_fail++; $display("FAIL single_ops: got %h %h expected 3fa00000 3fc00000", mul_op1, mul_op2); end
    wait_ack(20, lat, a);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, 3); end
    n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected %b", a, 4'b0001); end
    n_checks++; if ({rsp_result, rsp_overflow, rsp_timeout} !== {32'h3FF00000, 2'b00}) begin n_fail++; $display("FAIL single_rsp: got %h %b %b expected 3ff00000 0 0", rsp_result, rsp_overflow, rsp_timeout); end
    req = 4'b0000;
    @(negedge clk);
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected %b", ack, 4'b0000); end
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d expected %0d", start_cnt - s0, 1); end
  endtask

  task automatic test_simultaneous();
    int lat;
    logic [NUM_REQ-1:0] a;
    logic [31:0] exp_res [4];
    exp_res[0] = 32'h40C00000; exp_res[1] = 32'h41A00000;
    exp_res[2] = 32'h40400000; exp_res[3] = 32'h40800000;
    apply_reset();
    set_ops(0, 32'h40000000, 32'h40400000);
    set_ops(1, 32'h40800000, 32'h40A00000);
    set_ops(2, 32'h3FC00000, 32'h40000000);
    set_ops(3, 32'h3F000000, 32'h41000000);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(20, lat, a);
      n_checks++; if (a !== (4'b0001 << i)) begin n_fail++; $display("FAIL simul_grant%0d: got %b expected %b", i, a, 4'b0001 << i); end
      n_checks++; if (rsp_result !== exp_res[i]) begin n_fail++; $display("FAIL simul_result%0d: got %h expected %h", i, rsp_result, exp_res[i]); end
      req[i] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int lat;
    logic [NUM_REQ-1:0] a;
    logic [NUM_REQ-1:0] exp_a;
    logic [31:0] exp_r;
    apply_reset();
    set_ops(0, 32'h40000000, 32'h40200000);
    set_ops(2, 32'h3FA00000, 32'h3FC00000);
    req = 4'b0101;
    for (int n = 0; n < 6; n++) begin
      exp_a = (n % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_r = (n % 2 == 0) ? 32'h40A00000 : 32'h3FF00000;
      wait_ack(20, lat, a);
      n_checks++; if (a !== exp_a) begin n_fail++; $display("FAIL fair_grant%0d: got %b expected %b", n, a, exp_a); end
      n_checks++; if (rsp_result !== exp_r) begin n_fail++; $display("FAIL fair_result%0d: got %h expected %h", n, rsp_result, exp_r); end
      req = req & ~exp_a;
      @(negedge clk);
      req = 4'b0101;
    end
    req = 4'b0000;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    logic [NUM_REQ-1:0] a;
    apply_reset();
    model_delay = 0;
    set_ops(1, 32'h40000000, 32'h40400000);
    req = 4'b0010;
    wait_ack(100, lat, a);
    n_checks++; if (lat !== TIMEOUT + 2) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TIMEOUT + 2); end
    n_checks++; if (a !== 4'b0010) begin n_fail++; $display("FAIL timeout_ack: got %b expected %b", a, 4'b0010); end
    n_checks++; if ({rsp_result, rsp_overflow, rsp_timeout} !== {32'h0, 2'b01}) begin n_fail++; $display("FAIL timeout_rsp: got %h %b %b expected 00000000 0 1", rsp_result, rsp_overflow, rsp_timeout); end
    req = 4'b0000;
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    n_checks++; if ({rsp_result, rsp_timeout, busy, ack} !== {32'h0, 1'b1, 1'b0, 4'b0000}) begin n_fail++; $display("FAIL late_done_ignored: got %h %b %b %b expected 00000000 1 0 0000", rsp_result, rsp_timeout, busy, ack); end
    model_delay = 1;
    set_ops(2, 32'h3FC00000, 32'h40000000);
    req = 4'b0100;
    wait_ack(20, lat, a);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL recover_latency: got %0d expected %0d", lat, 3); end
    n_checks++; if ({a, rsp_result, rsp_timeout} !== {4'b0100, 32'h40400000, 1'b0}) begin n_fail++; $display("FAIL recover_rsp: got %b %h %b expected 0100 40400000 0", a, rsp_result, rsp_timeout); end
    req = 4'b0000;
  endtask

  task automatic test_overflow();
    int lat;
    logic [NUM_REQ-1:0] a;
    @(negedge clk);
    model_delay = 2;
    model_ovf = 1'b1;
    set_ops(3, 32'hC0400000, 32'hC0800000);
    req = 4'b1000;
    wait_ack(20, lat, a);
    n_checks++; if (a !== 4'b1000) begin n_fail++; $display("FAIL ovf_ack: got %b expected %b", a, 4'b1000); end
    n_checks++; if ({rsp_result, rsp_overflow, rsp_timeout} !== {32'h41400000, 2'b10}) begin n_fail++; $display("FAIL ovf_rsp: got %h %b %b expected 41400000 1 0", rsp_result, rsp_overflow, rsp_timeout); end
    req = 4'b0000;
    model_ovf = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    logic [NUM_REQ-1:0] a;
    @(negedge clk);
    model_delay = 2;
    set_ops(1, 32'h3F800000, 32'h40E00000);
    req = 4'b0010;
    wait_ack(20, lat, a);
    n_checks++; if (a !== 4'b0010) begin n_fail++; $display("FAIL rst_pre_ack: got %b expected %b", a, 4'b0010); end
    req = 4'b0000;
    @(negedge clk);
    model_delay = 0;
    set_ops(3, 32'h40000000, 32'h40400000);
    req = 4'b1010;
    repeat (5) @(negedge clk);
    n_checks++; if ({busy, mul_op1} !== {1'b1, 32'h40000000}) begin n_fail++; $display("FAIL rst_inflight: got %b %h expected 1 40000000", busy, mul_op1); end
    n_rst = 1'b0;
    #1;
    n_checks++; if ({ack, busy, mul_start} !== 6'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b expected %b", {ack, busy, mul_start}, 6'b0); end
    n_checks++; if ({mul_op1, mul_op2, rsp_result, rsp_overflow, rsp_timeout} !== 98'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 0", {mul_op1, mul_op2, rsp_result, rsp_overflow, rsp_timeout}); end
    @(negedge clk);
    n_rst = 1'b1;
    model_delay = 2;
    wait_ack(20, lat, a);
    n_checks++; if ({a, rsp_result} !== {4'b0010, 32'h40E00000}) begin n_fail++; $display("FAIL rst_first_grant: got %b %h expected 0010 40e00000", a, rsp_result); end
    req = 4'b1000;
    wait_ack(20, lat, a);
    n_checks++; if ({a, rsp_result} !== {4'b1000, 32'h40C00000}) begin n_fail++; $display("FAIL rst_second_grant: got %b %h expected 1000 40c00000", a, rsp_result); end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_overflow();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule
